m_mux3_arb: RTL and testbench

Round-robin scheduler that owns the select lines of the three-input counter-source multiplexer (A/B/C with SEL_0/SEL_1 encoding) in the Slipstream counter section. Three requesters compete for the shared path. The block grants one requester at a time, drives the matching SEL_0/SEL_1 code, and supports locked multi-cycle holds with a fairness limit. A one-cycle turnaround is inserted between owners.

---
 rtl/m_mux3_arb_pkg.sv | 39 +++
 rtl/m_mux3_arb_rr3_pick.sv | 32 +++
 rtl/m_mux3_arb.sv | 103 ++++++++++
 tb/tb_m_mux3_arb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/m_mux3_arb_pkg.sv
// Shared definitions for the Slipstream counter-source mux arbiter:
// source indices, FSM states and the source-to-select encoding.
package m_mux3_arb_pkg;

    typedef logic [1:0] src_t;

    localparam src_t SRC_A = 2'd0;
    localparam src_t SRC_B = 2'd1;
    localparam src_t SRC_C = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    // Returns {SEL_1, SEL_0}; 2'b11 is never produced.
    function automatic logic [1:0] sel_encode(src_t s);
        case (s)
            SRC_B:   return 2'b01;
            SRC_C:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] src_onehot(src_t s);
        case (s)
            SRC_A:   return 3'b001;
            SRC_B:   return 3'b010;
            SRC_C:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic src_t rr_next(src_t s);
        return (s == SRC_C) ? SRC_A : src_t'(s + 2'd1);
    endfunction

endpackage

// File: rtl/m_mux3_arb_rr3_pick.sv
// Combinational round-robin picker over three requesters; the search
// starts at the source after the last winner.
module m_rr3_pick
    import m_mux3_arb_pkg::*;
(
    input  logic [2:0] req_i,
    input  src_t       last_i,
    output src_t       win_o,
    output logic       valid_o
);

    src_t c0, c1, c2;

    assign c0 = rr_next(last_i);
    assign c1 = rr_next(c0);
    assign c2 = rr_next(c1);

    always_comb begin
        win_o   = SRC_A;
        valid_o = 1'b1;
        if (req_i[c0]) begin
            win_o = c0;
        end else if (req_i[c1]) begin
            win_o = c1;
        end else if (req_i[c2]) begin
            win_o = c2;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/m_mux3_arb.sv
// Round-robin owner of the A/B/C counter-source mux selects, with locked
// holds bounded by MAXHOLD and a one-cycle turnaround between owners.
module m_mux3_arb
    import m_mux3_arb_pkg::*;
#(
    parameter int unsigned MAXHOLD = 15
) (
    input  logic       MasterClock,
    input  logic       reset,
    input  logic       ENABLE,
    input  logic [2:0] REQ,
    input  logic [2:0] LOCK,
    output logic       SEL_0,
    output logic       SEL_1,
    output logic [2:0] GNT,
    output logic       BUSY,
    output logic [1:0] LAST
);

    localparam logic [3:0] MAXHOLD_W = MAXHOLD[3:0];

    state_t     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    src_t       last_q, last_d;
    logic [3:0] hold_q, hold_d;

    src_t       pick_win;
    logic       pick_vld;
    logic [3:0] hold_inc;
    logic       under_limit;
    logic       keep;

    m_rr3_pick u_pick (
        .req_i   (REQ),
        .last_i  (last_q),
        .win_o   (pick_win),
        .valid_o (pick_vld)
    );

    // hold_inc counts grant cycles including the current one.
    assign hold_inc    = (hold_q == 4'hF) ? 4'hF : hold_q + 4'd1;
    assign under_limit = (MAXHOLD_W == 4'd0) || (hold_inc < MAXHOLD_W);
    assign keep        = REQ[last_q] && LOCK[last_q] && under_limit;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                gnt_d = 3'b000;
                if (ENABLE && pick_vld) begin
                    state_d = ST_GRANT;
                    gnt_d   = src_onehot(pick_win);
                    sel_d   = sel_encode(pick_win);
                    last_d  = pick_win;
                    hold_d  = 4'd0;
                end
            end
            ST_GRANT: begin
                hold_d = hold_inc;
                if (!keep) begin
                    state_d = ST_TURN;
                    gnt_d   = 3'b000;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge MasterClock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 3'b000;
            sel_q   <= 2'b00;
            last_q  <= SRC_C;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign GNT   = gnt_q;
    assign SEL_1 = sel_q[1];
    assign SEL_0 = sel_q[0];
    assign BUSY  = (state_q != ST_IDLE);
    assign LAST  = last_q;

endmodule

// File: tb/tb_m_mux3_arb.sv
// Bench for m_mux3_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an owner/turn model.
module tb_m_mux3_arb;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ENABLE = 1'b1;
    logic [2:0] REQ = 3'b111;
    logic [2:0] LOCK = 3'b000;
    logic       SEL_0, SEL_1, BUSY;
    logic [2:0] GNT;
    logic [1:0] LAST;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    m_mux3_arb #(.MAXHOLD(MH)) dut (
        .MasterClock (clk),
        .reset       (reset),
        .ENABLE      (ENABLE),
        .REQ         (REQ),
        .LOCK        (LOCK),
        .SEL_0       (SEL_0),
        .SEL_1       (SEL_1),
        .GNT         (GNT),
        .BUSY        (BUSY),
        .LAST        (LAST)
    );

    // Model: who owns the path, how many cycles it has held it, whether a
    // turnaround cycle is in progress, and the last winner.
    typedef struct {
        int         own;
        int         held;
        bit         turn;
        int         last;
        logic [1:0] sel;
    } model_t;

    model_t m;
    bit     m_valid = 1'b0;

    function automatic model_t model_next(model_t s, bit rst, bit en,
                                          logic [2:0] req, logic [2:0] lock);
        model_t n = s;
        if (rst) begin
            n.own = -1; n.held = 0; n.turn = 1'b0; n.last = 2; n.sel = 2'b00;
        end else if (s.own >= 0) begin
            if (req[s.own] && lock[s.own] && (MH == 0 || s.held < MH)) begin
                n.held = s.held + 1;
            end else begin
                n.own = -1;
                n.turn = 1'b1;
            end
        end else if (s.turn) begin
            n.turn = 1'b0;
        end else if (en && req != 3'b000) begin
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (s.last + k) % 3;
                if (req[idx] && n.own < 0) n.own = idx;
            end
            n.last = n.own;
            n.held = 1;
            n.sel  = 2'(n.own);
        end
        return n;
    endfunction

    function automatic logic [2:0] exp_gnt(model_t s);
        case (s.own)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, reset, ENABLE, REQ, LOCK);
        if (reset) m_valid <= 1'b1;
    end

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_gnt",  {1'b0, GNT}, {1'b0, exp_gnt(m)});
            chk("model_sel",  {2'b00, SEL_1, SEL_0}, {2'b00, m.sel});
            chk("model_busy", {3'b000, BUSY}, {3'b000, (m.own >= 0) || m.turn});
            chk("model_last", {2'b00, LAST}, 4'(m.last));
            chk("sel_legal",  {3'b000, SEL_1 & SEL_0}, 4'd0);
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lit(string name, logic [2:0] g, logic [1:0] sel, logic b, logic [1:0] l);
        chk({name, "_gnt"},  {1'b0, GNT}, {1'b0, g});
        chk({name, "_sel"},  {2'b00, SEL_1, SEL_0}, {2'b00, sel});
        chk({name, "_busy"}, {3'b000, BUSY}, {3'b000, b});
        chk({name, "_last"}, {2'b00, LAST}, {2'b00, l});
    endtask

    task automatic go_idle();
        REQ = 3'b000; LOCK = 3'b000; ENABLE = 1'b1;
        tick(4);
    endtask

    initial begin
        // Reset with all requests pending.
        tick(3);
        lit("rst", 3'b000, 2'b00, 1'b0, 2'd2);
        reset = 1'b0;
        tick();
        lit("first", 3'b001, 2'b00, 1'b1, 2'd0);

        // Unlocked rotation A, B, C, A with a 3-cycle period.
        tick();  lit("rot_turn", 3'b000, 2'b00, 1'b1, 2'd0);
        tick();  lit("rot_idle", 3'b000, 2'b00, 1'b0, 2'd0);
        tick();  lit("rot_b",    3'b010, 2'b01, 1'b1, 2'd1);
        tick(3); lit("rot_c",    3'b100, 2'b10, 1'b1, 2'd2);
        tick(3); lit("rot_a",    3'b001, 2'b00, 1'b1, 2'd0);

        // Locked B bounded by MAXHOLD=4.
        go_idle();
        REQ = 3'b010; LOCK = 3'b010;
        for (int i = 1; i <= 4; i++) begin
            tick();
            lit("hold_b", 3'b010, 2'b01, 1'b1, 2'd1);
        end
        tick();  lit("hold_turn", 3'b000, 2'b01, 1'b1, 2'd1);
        tick();  lit("hold_idle", 3'b000, 2'b01, 1'b0, 2'd1);
        tick();  lit("hold_regrant", 3'b010, 2'b01, 1'b1, 2'd1);

        // Locked C released by REQ drop on its third grant cycle.
        go_idle();
        REQ = 3'b100; LOCK = 3'b100;
        tick(3); lit("c_hold3", 3'b100, 2'b10, 1'b1, 2'd2);
        REQ = 3'b000;
        tick();  lit("c_rel", 3'b000, 2'b10, 1'b1, 2'd2);
        REQ = 3'b111; LOCK = 3'b000;
        tick();  lit("c_idle", 3'b000, 2'b10, 1'b0, 2'd2);
        tick();  lit("c_next_a", 3'b001, 2'b00, 1'b1, 2'd0);

        // ENABLE gating.
        go_idle();
        ENABLE = 1'b0; REQ = 3'b100;
        tick(3); lit("en_off", 3'b000, 2'b00, 1'b0, 2'd0);
        ENABLE = 1'b1;
        tick();  lit("en_on", 3'b100, 2'b10, 1'b1, 2'd2);

        // Reset in the middle of a locked B grant.
        go_idle();
        REQ = 3'b010; LOCK = 3'b010;
        tick(2); lit("pre_rst", 3'b010, 2'b01, 1'b1, 2'd1);
        reset = 1'b1;
        tick();  lit("mid_rst", 3'b000, 2'b00, 1'b0, 2'd2);
        reset = 1'b0;

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) REQ = 3'($urandom_range(0, 7));
            LOCK   = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
            ENABLE = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
